// File: rtl/param_perceptron.sv
// Single-layer perceptron: serial feature load, signed MAC, sign decision and
// saturating online weight update. Optional error counter: PERCEPTRON_ERR_CNT_EN.
`timescale 1ns/1ps

module param_perceptron #(
  parameter int N_IN     = 4,
  parameter int DW       = 6,
  parameter int LR_SHIFT = 0
) (
  input  logic                 clock,
  input  logic                 reset,
  input  logic                 go,
  input  logic                 update,
  input  logic                 correct,
  input  logic                 in_valid,
  input  logic signed [DW-1:0] in_val,
  input  logic [1:0]           sel_out,
  output logic                 done,
  output logic                 classification,
  output logic                 sync,
  output logic [DW-1:0]        out_val
);

  localparam int ACC_W = 2*DW + $clog2(N_IN+1);
  localparam int IDX_W = $clog2(N_IN+1);
  localparam int RD_W  = $clog2(N_IN);
  localparam int SUM_W = DW + 2;
  localparam logic signed [SUM_W-1:0] POS_LIM = SUM_W'((1 << (DW-1)) - 1);
  localparam logic signed [SUM_W-1:0] NEG_LIM = -POS_LIM;
  localparam logic signed [SUM_W-1:0] ONE     = SUM_W'(1);

  typedef enum logic [2:0] {IDLE, LOAD, DECIDE, UPDATE, DONE} state_t;

  state_t                    state, state_next;
  logic signed [DW-1:0]      w [N_IN];
  logic signed [DW-1:0]      x [N_IN];
  logic signed [DW-1:0]      bias;
  logic signed [ACC_W-1:0]   acc;
  logic [IDX_W-1:0]          idx;
  logic                      upd_l, corr_l;

  logic [RD_W-1:0]           ix;
  logic [RD_W-1:0]           rd_ix;
  logic signed [2*DW-1:0]    prod;
  logic signed [SUM_W-1:0]   x_ext, delta, w_sum, bias_sum;
  logic signed [DW-1:0]      w_sat, bias_sat;
  logic                      acc_nonneg, mispredict, idx_last_feat, idx_at_n;
  logic [2+IDX_W:0]          status;

  // Symmetric clamp keeps -(2^(DW-1)) unreachable so negation never overflows.
  function automatic logic signed [DW-1:0] sat(input logic signed [SUM_W-1:0] v);
    if (v > POS_LIM)      return DW'(POS_LIM);
    else if (v < NEG_LIM) return DW'(NEG_LIM);
    else                  return DW'(v);
  endfunction

  // NOTE: every signal written in always_comb gets a default first, so no path leaves it unassigned and no latch is inferred.
  always_comb begin
    ix            = idx[RD_W-1:0];
    prod          = w[ix] * in_val;
    x_ext         = SUM_W'(x[ix]);
    delta         = (corr_l ? x_ext : -x_ext) >>> LR_SHIFT;
    w_sum         = SUM_W'(w[ix]) + delta;
    w_sat         = sat(w_sum);
    bias_sum      = SUM_W'(bias) + (corr_l ? ONE : -ONE);
    bias_sat      = sat(bias_sum);
    acc_nonneg    = ~acc[ACC_W-1];
    mispredict    = (acc_nonneg != corr_l);
    idx_last_feat = (idx == IDX_W'(N_IN-1));
    idx_at_n      = (idx == IDX_W'(N_IN));
  end

  // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
  always_ff @(posedge clock) begin
    if (reset) state <= IDLE;
    else       state <= state_next;
  end

  always_comb begin
    state_next = state;
    case (state)
      IDLE:    if (go) state_next = LOAD;
      LOAD:    if (in_valid && idx_last_feat) state_next = DECIDE;
      DECIDE:  state_next = (upd_l && mispredict) ? UPDATE : DONE;
      UPDATE:  if (idx_at_n) state_next = DONE;
      DONE:    state_next = IDLE;
      default: state_next = IDLE;
    endcase
  end

  always_comb begin
    done = (state == DONE);
    sync = (state == LOAD);
  end

  // NOTE: weight and feature arrays are cleared on reset because an aborted pass must not leave partial learning behind.
  always_ff @(posedge clock) begin
    if (reset) begin
      bias           <= '0;
      acc            <= '0;
      idx            <= '0;
      upd_l          <= 1'b0;
      corr_l         <= 1'b0;
      classification <= 1'b0;
      for (int i = 0; i < N_IN; i++) begin
        w[i] <= '0;
        x[i] <= '0;
      end
    end else begin
      case (state)
        IDLE: if (go) begin
          upd_l  <= update;
          corr_l <= correct;
          acc    <= ACC_W'(bias);
          idx    <= '0;
          for (int i = 0; i < N_IN; i++) x[i] <= '0;
        end
        LOAD: if (in_valid) begin
          x[ix] <= in_val;
          acc   <= acc + ACC_W'(prod);
          idx   <= idx + IDX_W'(1);
        end
        DECIDE: begin
          classification <= acc_nonneg;
          idx            <= '0;
        end
        UPDATE: begin
          if (idx_at_n) bias  <= bias_sat;
          else          w[ix] <= w_sat;
          idx <= idx + IDX_W'(1);
        end
        default: ;
      endcase
    end
  end

`ifdef PERCEPTRON_ERR_CNT_EN
  logic [DW-1:0] err_cnt;

  always_ff @(posedge clock) begin
    if (reset)
      err_cnt <= '0;
    else if (state == DECIDE && mispredict && !(&err_cnt))
      err_cnt <= err_cnt + DW'(1);
  end
`endif

  always_comb begin
    status = {state, idx};
    rd_ix  = in_val[RD_W-1:0];
    case (sel_out)
      2'b00:   out_val = (int'(rd_ix) < N_IN) ? w[rd_ix] : '0;
      2'b01:   out_val = bias;
      2'b10:   out_val = acc[ACC_W-1 -: DW];
`ifdef PERCEPTRON_ERR_CNT_EN
      default: out_val = err_cnt;
`else
      default: out_val = DW'(status);
`endif
    endcase
  end

endmodule

// File: tb/tb_param_perceptron.sv
// Self-checking bench for param_perceptron: directed scenarios plus randomized
// passes compared against an arithmetic reference model.
`timescale 1ns/1ps

module tb_param_perceptron;

  localparam int N_IN     = 4;
  localparam int DW       = 6;
  localparam int LR_SHIFT = 0;
  localparam int ACC_W    = 2*DW + $clog2(N_IN+1);
  localparam int WMAX     = (1 << (DW-1)) - 1;

  logic          clock = 1'b0;
  logic          reset = 1'b1;
  logic          go = 1'b0, update = 1'b0, correct = 1'b0, in_valid = 1'b0;
  logic [DW-1:0] in_val = '0;
  logic [1:0]    sel_out = 2'b00;
  logic          done, classification, sync;
  logic [DW-1:0] out_val;

  param_perceptron #(.N_IN(N_IN), .DW(DW), .LR_SHIFT(LR_SHIFT)) dut (
    .clock(clock), .reset(reset), .go(go), .update(update), .correct(correct),
    .in_valid(in_valid), .in_val(in_val), .sel_out(sel_out), .done(done),
    .classification(classification), .sync(sync), .out_val(out_val)
  );

  always #5 clock = ~clock;

  int n_checks = 0;
  int n_passed = 0;

  // Reference model state
  int mw[N_IN];
  int mb, mcls, merr, m_acc, m_lat;
  int feat[N_IN];

  task automatic check(input string tag, input int got, input int exp);
    n_checks++;
    if (got == exp) n_passed++;
    else $display("FAIL %s: got %0d expected %0d", tag, got, exp);
  endtask

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  function automatic int sat(input int v);
    if (v > WMAX)  return WMAX;
    if (v < -WMAX) return -WMAX;
    return v;
  endfunction

  task automatic model_reset();
    for (int i = 0; i < N_IN; i++) mw[i] = 0;
    mb = 0; mcls = 0; merr = 0;
  endtask

  task automatic model_pass(input bit upd, input bit corr, input int gap);
    int a;
    bit mis;
    a = mb;
    for (int i = 0; i < N_IN; i++) a += mw[i] * feat[i];
    m_acc = a;
    mcls  = (a >= 0) ? 1 : 0;
    mis   = (mcls != int'(corr));
    if (mis && merr < (1 << DW) - 1) merr++;
    if (upd && mis) begin
      for (int i = 0; i < N_IN; i++)
        mw[i] = sat(mw[i] + ((corr ? feat[i] : -feat[i]) >>> LR_SHIFT));
      mb = sat(mb + (corr ? 1 : -1));
    end
    m_lat = ((upd && mis) ? 2*N_IN + 3 : N_IN + 2) + (N_IN - 1) * gap;
  endtask

  task automatic rd(input logic [1:0] s, input int ix, output int v);
    sel_out = s;
    in_val  = DW'(ix);
    #1;
    v = int'($signed(out_val));
  endtask

  task automatic check_weights(input string tag);
    int v;
    for (int i = 0; i < N_IN; i++) begin
      rd(2'b00, i, v);
      check($sformatf("%s_w%0d", tag, i), v, mw[i]);
    end
    rd(2'b01, 0, v);
    check({tag, "_bias"}, v, mb);
  endtask

  task automatic do_reset();
    reset = 1'b1; go = 1'b0; in_valid = 1'b0;
    tick(); tick();
    reset = 1'b0;
    model_reset();
  endtask

  // Runs one full pass; gap idle cycles precede every feature after the first.
  task automatic run_pass(input bit upd, input bit corr, input int gap,
                          input bit go_noise, input string tag);
    int cyc, v;
    bit sync_ok;
    model_pass(upd, corr, gap);
    update = upd; correct = corr; in_valid = 1'b0; go = 1'b1;
    tick();
    cyc = 1; go = 1'b0; sync_ok = 1'b1;
    for (int i = 0; i < N_IN; i++) begin
      if (i > 0) begin
        for (int g = 0; g < gap; g++) begin
          go = go_noise; in_valid = 1'b0;
          if (!sync) sync_ok = 1'b0;
          tick(); cyc++;
        end
      end
      go = 1'b0; in_valid = 1'b1; in_val = DW'(feat[i]);
      if (!sync) sync_ok = 1'b0;
      tick(); cyc++;
    end
    in_valid = 1'b0; in_val = '0; go = 1'b0;
    while (!done && cyc < 200) begin
      tick(); cyc++;
    end
    check({tag, "_latency"}, cyc, m_lat);
    check({tag, "_sync"}, int'(sync_ok), 1);
    check({tag, "_class"}, int'(classification), mcls);
    rd(2'b10, 0, v);
    check({tag, "_acc_hi"}, v, m_acc >>> (ACC_W - DW));
    tick();
    check({tag, "_done_pulse"}, int'(done), 0);
    check_weights(tag);
  endtask

  initial begin
    int v;
    do_reset();

    // Reset state
    check("rst_done", int'(done), 0);
    check("rst_class", int'(classification), 0);
    check("rst_sync", int'(sync), 0);
    rd(2'b11, 0, v); check("rst_status", v, 0);
    rd(2'b10, 0, v); check("rst_acc", v, 0);
    check_weights("rst");

    // Learning pass: acc = 0 -> class 1, target 0 -> update
    feat = '{1, 2, 3, 4};
    run_pass(1'b1, 1'b0, 0, 1'b0, "learn");
    check("learn_acc_zero", m_acc, 0);
    rd(2'b00, 0, v); check("learn_w0_const", v, -1);
    rd(2'b00, 3, v); check("learn_w3_const", v, -4);
    rd(2'b01, 0, v); check("learn_bias_const", v, -1);

    // Correct prediction: acc = -11, no update
    feat = '{1, 1, 1, 1};
    run_pass(1'b1, 1'b0, 0, 1'b0, "noupd");
    check("noupd_acc_const", m_acc, -11);
    rd(2'b00, 2, v); check("noupd_w2_const", v, -3);

    // Feature gaps of 3 cycles with go noise during LOAD
    feat = '{2, -3, 5, 1};
    run_pass(1'b0, 1'b1, 3, 1'b1, "gaps");

    // Positive saturation: w0 = 29 then +5 clamps to 31
    do_reset();
    feat = '{-29, 31, 0, 0};
    run_pass(1'b1, 1'b0, 0, 1'b0, "satp_a");
    feat = '{5, 31, 0, 0};
    run_pass(1'b1, 1'b1, 0, 1'b0, "satp_b");
    rd(2'b00, 0, v); check("satp_w0_const", v, 31);

    // Negative saturation: w0 = -29 then -5 clamps to -31
    do_reset();
    feat = '{29, 31, 0, 0};
    run_pass(1'b1, 1'b0, 0, 1'b0, "satn_a");
    feat = '{5, -31, 0, 0};
    run_pass(1'b1, 1'b0, 0, 1'b0, "satn_b");
    rd(2'b00, 0, v); check("satn_w0_const", v, -31);

    // Reset in the middle of UPDATE after w[0] has been written
    do_reset();
    feat = '{3, 4, 5, 6};
    update = 1'b1; correct = 1'b0; go = 1'b1;
    tick(); go = 1'b0;
    for (int i = 0; i < N_IN; i++) begin
      in_valid = 1'b1; in_val = DW'(feat[i]);
      tick();
    end
    in_valid = 1'b0;
    tick(); tick();
    rd(2'b00, 0, v); check("midupd_w0_written", v, -3);
    reset = 1'b1;
    tick();
    reset = 1'b0;
    model_reset();
    check("midupd_done", int'(done), 0);
    rd(2'b11, 0, v); check("midupd_status", v, 0);
    check_weights("midupd");

`ifdef PERCEPTRON_ERR_CNT_EN
    do_reset();
    feat = '{1, 2, 3, 4};
    for (int p = 0; p < 3; p++) run_pass(1'b0, 1'b0, 0, 1'b0, "errcnt");
    rd(2'b11, 0, v); check("errcnt_value", v, 3);
    check("errcnt_model", merr, 3);
`endif

    // Randomized passes against the reference model
    do_reset();
    for (int p = 0; p < 40; p++) begin
      for (int i = 0; i < N_IN; i++) feat[i] = int'($urandom_range(0, 63)) - 32;
      run_pass(1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
               int'($urandom_range(0, 2)), 1'($urandom_range(0, 1)),
               $sformatf("rnd%0d", p));
`ifdef PERCEPTRON_ERR_CNT_EN
      rd(2'b11, 0, v); check($sformatf("rnd%0d_errcnt", p), v, merr);
`endif
    end

    $display("%0d/%0d checks passed", n_passed, n_checks);
    $finish;
  end

endmodule

// File: doc/param_perceptron.md
PARAM_PERCEPTRON -- requirements
Module: param_perceptron

Interface
REQ-001 Parameter N_IN, default 4, number of input features (2..16).
REQ-002 Parameter DW, default 6, signed width of features, weights and bias.
REQ-003 Parameter LR_SHIFT, default 0, learning-rate arithmetic right shift applied to each weight delta.
REQ-004 The accumulator width SHALL be ACC_W = 2*DW + clog2(N_IN+1), derived internally and not user-settable.
REQ-005 The clock port SHALL be `clock`, input, 1 bit: the single clock, with all logic on its rising edge.
REQ-006 The reset port SHALL be `reset`, input, 1 bit: synchronous, active-high.
REQ-007 The ports SHALL be:
- go  input  1  start a classification pass.
- update  input  1  sampled with go; enables learning for that pass.
- correct  input  1  sampled with go; target label (1 = positive class).
- in_valid  input  1  in_val carries a feature this cycle.
- in_val  input  DW  signed feature; in IDLE, the low bits form the readback index.
- sel_out  input  2  readback select.
- done  output  1  one-cycle completion pulse.
- classification  output  1  last decision (1 = acc >= 0).
- sync  output  1  high while the block accepts features.
- out_val  output  DW  readback data.

Function
REQ-008 The FSM SHALL have the states IDLE, LOAD, DECIDE, UPDATE and DONE.
REQ-009 In IDLE, go=1 SHALL latch update and correct, set acc to the sign-extended bias, clear idx and buffered features, and enter LOAD on the next cycle.
REQ-010 In LOAD, sync SHALL be 1; each cycle with in_valid=1 SHALL store x[idx]=in_val, do acc += w[idx]*x[idx] (signed, full width), and increment idx; in_valid=0 SHALL stall with no change.
REQ-011 After the N_IN-th accepted feature, the FSM SHALL enter DECIDE; acc SHALL never overflow.
REQ-012 In DECIDE (one cycle), classification SHALL be set to (acc >= 0); next state SHALL be UPDATE if latched update=1 and classification != latched correct, otherwise DONE.
REQ-013 UPDATE SHALL take N_IN+1 cycles:
- cycle i<N_IN: w[i] += (correct ? x[i] : -x[i]) >>> LR_SHIFT.
- final cycle: bias += (correct ? +1 : -1).
- all results saturate to [-(2^(DW-1)-1), 2^(DW-1)-1].
REQ-014 DONE SHALL assert done for exactly one cycle, then return to IDLE.
REQ-015 go outside IDLE SHALL be ignored; in_valid outside LOAD SHALL be ignored.
REQ-016 classification SHALL hold its value until the next DECIDE.
REQ-017 Latency with continuous in_valid, go sampled at cycle t: done at t+N_IN+2 without update, t+2*N_IN+3 with update.
REQ-018 sel_out (combinational from registered state) SHALL select out_val as:
- 00: w[in_val[clog2(N_IN)-1:0]] (index valid only in IDLE; out-of-range index returns 0).
- 01: bias.
- 10: acc[ACC_W-1 -: DW].
- 11: status = {state[2:0], idx} zero-padded or truncated to DW.

Reset
REQ-019 On reset, all weights, bias, acc, idx and features SHALL be cleared to 0; the state SHALL go to IDLE; done, classification and sync SHALL be 0.
REQ-020 Reset SHALL abort any in-progress pass with no partial weight update retained.

Configuration
REQ-021 With PERCEPTRON_ERR_CNT_EN defined, a DW-bit counter SHALL increment (saturating at all-ones) on each DECIDE that mispredicts latched correct, regardless of update; sel_out=11 SHALL return the counter; reset SHALL clear it.
REQ-022 Without PERCEPTRON_ERR_CNT_EN, no counter SHALL exist and sel_out=11 SHALL return status.

Verification
REQ-023 N_IN=4, DW=6, after reset: go with update=1 and correct=0; features 1,2,3,4 -> acc=0, classification=1, done at t+11; then w={-1,-2,-3,-4} and bias=-1.
REQ-024 Same weights, go with update=1 and correct=0, features 1,1,1,1 -> acc=-11, classification=0, no update, done at t+6, weights unchanged.
REQ-025 Saturation: w[0]=29, correct=1 misclassified with x[0]=5 -> w[0]=31 (not wrapping); w[0]=-29 with -x=-5 -> -31.
REQ-026 in_valid gaps of 3 cycles between features -> sync stays 1 and done is delayed by exactly 9 cycles; go pulses during LOAD are ignored.
REQ-027 Reset asserted mid-UPDATE after w[0] is written -> all weights 0, state IDLE, done=0.
REQ-028 With PERCEPTRON_ERR_CNT_EN, run 3 mispredicting passes with update=0 -> sel_out=11 gives 3 and weights stay 0.
